// File: rtl/lpdi_right_volume_lr.sv
// lpdi_right_volume_lr
// Builds the right-view aggregated cost volume Lr(x,d) = Ll(x+d,d) from the
// streamed left-view volume Ll(x,.). A D-deep stage array holds the last D
// accepted left pixels. Each output pixel is gathered diagonally across the
// array. After end-of-line the block injects D padding pixels so that the
// line tail drains out and the next line never mixes with it. Disparities
// that fall off the end of a line are replaced with INVALID_COST.
//
// Optional feature macro: LPDI_LEFT_PASSTHRU_EN
//   When defined, the block adds an output LPDiLeft. It carries Ll(x,.) and is
//   registered alongside the matching Lr(x,.).
module lpdi_right_volume_lr #(
  parameter int                    MAXDISPARITY = 64,
  parameter int                    LPDI_WIDTH   = 8,
  parameter logic [LPDI_WIDTH-1:0] INVALID_COST = {LPDI_WIDTH{1'b1}}
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               pixelEN,
  output logic                               in_ready,
  input  logic                               sof_in,
  input  logic                               eol_in,
  input  logic [MAXDISPARITY*LPDI_WIDTH-1:0] LPDiLeft_in,
  output logic                               out_valid,
  output logic [MAXDISPARITY*LPDI_WIDTH-1:0] LPDiRight,
  output logic                               sof_out,
  output logic                               eol_out,
  output logic                               sof_err
`ifdef LPDI_LEFT_PASSTHRU_EN
  ,
  output logic [MAXDISPARITY*LPDI_WIDTH-1:0] LPDiLeft
`endif
);

  localparam int D      = MAXDISPARITY;
  localparam int W      = LPDI_WIDTH;
  localparam int VW     = D * W;
  localparam int CNT_W  = (D > 2) ? $clog2(D) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // FSM and flush counter
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  // Stage array: stage 0 holds the newest pixel, stage D-1 the oldest.
  logic [VW-1:0]      stg_data_q [D];
  logic [VW-1:0]      stg_data_d [D];
  logic [D-1:0]       stg_vld_q, stg_vld_d;
  logic [D-1:0]       stg_sof_q, stg_sof_d;
  logic [D-1:0]       stg_eol_q, stg_eol_d;

  // Output registers
  logic               out_valid_q, out_valid_d;
  logic [VW-1:0]      right_q, right_d;
  logic               sof_out_q, sof_out_d;
  logic               eol_out_q, eol_out_d;
  logic               sof_err_q, sof_err_d;

  // Handshake and control terms
  logic               accept;
  logic               advance;
  logic               mid_sof;
  logic [D-1:0]       vld_eff;
  logic               out_fire;
  logic [VW-1:0]      right_gather;

  assign in_ready = en && (state_q == ST_RUN);
  assign accept   = pixelEN && in_ready;
  assign advance  = en && (accept || (state_q == ST_FLUSH));

  // A SOF that arrives while earlier pixels of a line are still in flight
  // aborts that line. The older pixels lose their valid bit before the shift.
  assign mid_sof  = accept && sof_in && (|stg_vld_q) && (state_q == ST_RUN);
  assign vld_eff  = mid_sof ? '0 : stg_vld_q;

  // An output pixel exists only if the oldest stage still holds a real pixel.
  assign out_fire = advance && vld_eff[D-1];

  // Diagonal gather. Element d comes from the pixel d columns to the right.
  // Stage D-1-d holds that pixel while stage D-1 holds pixel x.
  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_gather
      assign right_gather[gi*W +: W] = vld_eff[D-1-gi]
                                       ? stg_data_q[D-1-gi][gi*W +: W]
                                       : INVALID_COST;
    end
  endgenerate

  // Next state: leave RUN on an accepted EOL. Then spend exactly D advances
  // in FLUSH so the line tail reaches the output.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          if (accept && eol_in) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == CNT_W'(D - 1)) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Stage shift. In FLUSH, a padding pixel with vld=0 enters stage 0.
  // Its data is don't-care and the input bus is reused.
  always_comb begin
    for (int k = 0; k < D; k++) begin
      stg_data_d[k] = stg_data_q[k];
    end
    stg_vld_d = stg_vld_q;
    stg_sof_d = stg_sof_q;
    stg_eol_d = stg_eol_q;
    if (advance) begin
      stg_data_d[0] = LPDiLeft_in;
      stg_vld_d[0]  = accept;
      stg_sof_d[0]  = accept && sof_in;
      stg_eol_d[0]  = accept && eol_in;
      for (int k = 1; k < D; k++) begin
        stg_data_d[k] = stg_data_q[k-1];
        stg_vld_d[k]  = vld_eff[k-1];
        stg_sof_d[k]  = stg_sof_q[k-1];
        stg_eol_d[k]  = stg_eol_q[k-1];
      end
    end
  end

  // Stage array registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) begin
        stg_data_q[k] <= '0;
      end
      stg_vld_q <= '0;
      stg_sof_q <= '0;
      stg_eol_q <= '0;
    end else begin
      for (int k = 0; k < D; k++) begin
        stg_data_q[k] <= stg_data_d[k];
      end
      stg_vld_q <= stg_vld_d;
      stg_sof_q <= stg_sof_d;
      stg_eol_q <= stg_eol_d;
    end
  end

  // Output capture. The strobes update every cycle; the payload holds
  // between strobes.
  always_comb begin
    out_valid_d = out_fire;
    sof_err_d   = mid_sof;
    right_d     = right_q;
    sof_out_d   = sof_out_q;
    eol_out_d   = eol_out_q;
    if (out_fire) begin
      right_d   = right_gather;
      sof_out_d = stg_sof_q[D-1];
      eol_out_d = stg_eol_q[D-1];
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      right_q     <= '0;
      sof_out_q   <= 1'b0;
      eol_out_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      right_q     <= right_d;
      sof_out_q   <= sof_out_d;
      eol_out_q   <= eol_out_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign LPDiRight = right_q;
  assign sof_out   = sof_out_q;
  assign eol_out   = eol_out_q;
  assign sof_err   = sof_err_q;

`ifdef LPDI_LEFT_PASSTHRU_EN
  logic [VW-1:0] left_q, left_d;

  // Ll(x,.) taken from the oldest stage, aligned with Lr(x,.)
  always_comb begin
    left_d = left_q;
    if (out_fire) begin
      left_d = stg_data_q[D-1];
    end
  end

  // Passthrough register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q <= '0;
    end else begin
      left_q <= left_d;
    end
  end

  assign LPDiLeft = left_q;
`else
  // Only element 0 of the oldest stage is needed without the passthrough.
  logic unused_tail;
  assign unused_tail = ^stg_data_q[D-1][VW-1:W];
`endif

endmodule

// File: tb/tb_lpdi_right_volume_lr.sv
// Testbench for lpdi_right_volume_lr with D=4, W=8, INVALID_COST=0xFF and
// Ll(x,d)=16x+d. Expected values are hand-computed constants in a table.
module tb_lpdi_right_volume_lr;

  localparam int D  = 4;
  localparam int W  = 8;
  localparam int VW = D * W;

  typedef struct {
    logic [VW-1:0] din;
    logic          sof;
    logic          eol;
    logic [VW-1:0] exp_r;
  } vec_t;

  vec_t vt [17];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          en_rand = 1'b0;
  logic          pixelEN = 1'b0;
  logic          sof_in = 1'b0;
  logic          eol_in = 1'b0;
  logic [VW-1:0] din = '0;
  logic          in_ready;
  logic          out_valid;
  logic [VW-1:0] LPDiRight;
  logic          sof_out;
  logic          eol_out;
  logic          sof_err;
`ifdef LPDI_LEFT_PASSTHRU_EN
  logic [VW-1:0] LPDiLeft;
`endif

  int tests = 0;
  int fails = 0;

  logic [VW-1:0] q_data [$];
  logic          q_sof  [$];
  logic          q_eol  [$];
`ifdef LPDI_LEFT_PASSTHRU_EN
  logic [VW-1:0] q_left [$];
`endif
  int            sof_err_cnt = 0;

  always #5 clk = ~clk;

  lpdi_right_volume_lr #(
    .MAXDISPARITY(D),
    .LPDI_WIDTH  (W),
    .INVALID_COST(8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pixelEN    (pixelEN),
    .in_ready   (in_ready),
    .sof_in     (sof_in),
    .eol_in     (eol_in),
    .LPDiLeft_in(din),
    .out_valid  (out_valid),
    .LPDiRight  (LPDiRight),
    .sof_out    (sof_out),
    .eol_out    (eol_out),
    .sof_err    (sof_err)
`ifdef LPDI_LEFT_PASSTHRU_EN
    ,
    .LPDiLeft   (LPDiLeft)
`endif
  );

  // Enable driver: constant 1, or random low bursts when en_rand is set.
  always @(posedge clk) begin
    #1;
    en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: one line per captured output pixel.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      q_data.push_back(LPDiRight);
      q_sof.push_back(sof_out);
      q_eol.push_back(eol_out);
`ifdef LPDI_LEFT_PASSTHRU_EN
      q_left.push_back(LPDiLeft);
`endif
      $display("[TB] out %0d: LPDiRight=%h sof=%0b eol=%0b", q_data.size() - 1, LPDiRight, sof_out, eol_out);
    end
    if (sof_err) sof_err_cnt = sof_err_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [VW-1:0] d, input logic s, input logic e);
    logic acc;
    din     = d;
    sof_in  = s;
    eol_in  = e;
    pixelEN = 1'b1;
    acc     = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
    pixelEN = 1'b0;
    sof_in  = 1'b0;
    eol_in  = 1'b0;
  endtask

  // Compare n captured outputs starting at queue index base with table rows.
  task automatic check_rows(input string nm, input int base, input int first, input int n);
    int got;
    got = q_data.size() - base;
    chk({nm, "_count"}, VW'(got), VW'(n));
    if (got >= n) begin
      for (int i = 0; i < n; i++) begin
        $display("[TB] %s row %0d: got %h exp %h", nm, i, q_data[base+i], vt[first+i].exp_r);
        chk({nm, "_data"}, q_data[base+i], vt[first+i].exp_r);
        chk({nm, "_sof"}, VW'(q_sof[base+i]), VW'(vt[first+i].sof));
        chk({nm, "_eol"}, VW'(q_eol[base+i]), VW'(vt[first+i].eol));
      end
    end
  endtask

  initial begin
    int base;
    int err_base;
    int lows;

    // Line of 6 pixels: rows 0..5
    vt[0]  = '{32'h03020100, 1'b1, 1'b0, 32'h33221100};
    vt[1]  = '{32'h13121110, 1'b0, 1'b0, 32'h43322110};
    vt[2]  = '{32'h23222120, 1'b0, 1'b0, 32'h53423120};
    vt[3]  = '{32'h33323130, 1'b0, 1'b0, 32'hFF524130};
    vt[4]  = '{32'h43424140, 1'b0, 1'b0, 32'hFFFF5140};
    vt[5]  = '{32'h53525150, 1'b0, 1'b1, 32'hFFFFFF50};
    // First 3-pixel line (x=8..10 data): rows 6..8
    vt[6]  = '{32'h83828180, 1'b1, 1'b0, 32'hFFA29180};
    vt[7]  = '{32'h93929190, 1'b0, 1'b0, 32'hFFFFA190};
    vt[8]  = '{32'hA3A2A1A0, 1'b0, 1'b1, 32'hFFFFFFA0};
    // Second 3-pixel line: rows 9..11
    vt[9]  = '{32'h03020100, 1'b1, 1'b0, 32'hFF221100};
    vt[10] = '{32'h13121110, 1'b0, 1'b0, 32'hFFFF2110};
    vt[11] = '{32'h23222120, 1'b0, 1'b1, 32'hFFFFFF20};
    // 4-pixel line restarted by a mid-line SOF: rows 12..15
    vt[12] = '{32'h03020100, 1'b1, 1'b0, 32'h33221100};
    vt[13] = '{32'h13121110, 1'b0, 1'b0, 32'hFF322110};
    vt[14] = '{32'h23222120, 1'b0, 1'b0, 32'hFFFF3120};
    vt[15] = '{32'h33323130, 1'b0, 1'b1, 32'hFFFFFF30};
    // Single-pixel line: row 16
    vt[16] = '{32'h03020100, 1'b1, 1'b1, 32'hFFFFFF00};

    // Reset values
    #2;
    chk("rst_out_valid", VW'(out_valid), '0);
    chk("rst_LPDiRight", LPDiRight, '0);
    chk("rst_sof_out", VW'(sof_out), '0);
    chk("rst_eol_out", VW'(eol_out), '0);
    chk("rst_sof_err", VW'(sof_err), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;

    // Test 1: 6-pixel line at full rate
    base = q_data.size();
    for (int i = 0; i < 6; i++) send(vt[i].din, vt[i].sof, vt[i].eol);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!in_ready) lows = lows + 1;
      else break;
    end
    $display("[TB] line6 in_ready low for %0d cycles", lows);
    chk("flush_ready_low", VW'(lows), VW'(4));
    idle(3);
    check_rows("line6", base, 0, 6);
`ifdef LPDI_LEFT_PASSTHRU_EN
    if (q_left.size() > base + 1) chk("passthru_x1", q_left[base+1], 32'h13121110);
    else chk("passthru_count", VW'(q_left.size()), VW'(base + 2));
`endif

    // Test 2: two back-to-back 3-pixel lines
    base = q_data.size();
    for (int i = 6; i < 12; i++) send(vt[i].din, vt[i].sof, vt[i].eol);
    idle(12);
    check_rows("b2b", base, 6, 6);

    // Test 3: random pixelEN gaps and en bursts, same line as test 1
    base = q_data.size();
    en_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 2));
      send(vt[i].din, vt[i].sof, vt[i].eol);
    end
    en_rand = 1'b0;
    idle(14);
    check_rows("gaps", base, 0, 6);

    // Test 4: SOF at x=2 restarts the line
    base     = q_data.size();
    err_base = sof_err_cnt;
    send(32'h83828180, 1'b1, 1'b0);
    send(32'h93929190, 1'b0, 1'b0);
    for (int i = 12; i < 16; i++) send(vt[i].din, vt[i].sof, vt[i].eol);
    idle(12);
    chk("midsof_err_pulses", VW'(sof_err_cnt - err_base), VW'(1));
    check_rows("midsof", base, 12, 4);

    // Test 5: reset asserted mid-FLUSH
    for (int i = 0; i < 5; i++) send(vt[i].din, (i == 0), (i == 4));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", VW'(out_valid), '0);
    chk("midrst_LPDiRight", LPDiRight, '0);
    chk("midrst_sof_out", VW'(sof_out), '0);
    chk("midrst_eol_out", VW'(eol_out), '0);
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;
    base = q_data.size();
    idle(8);
    chk("midrst_no_output", VW'(q_data.size() - base), '0);

    // Single-pixel line after reset
    base = q_data.size();
    send(vt[16].din, vt[16].sof, vt[16].eol);
    idle(8);
    check_rows("single", base, 16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
